stage_mem_lsu: RTL

- Parametrised MEM pipeline stage with a real load/store unit. Sits between the EX/MEM register and the MEM/WB path.
- Executes loads and stores over a byte-wide, little-endian memory port, one byte per cycle. Raises stall_req_o while a multi-cycle access is in flight.
- Non-memory instructions pass through with a one-cycle registered latency.
- Loads return sign- or zero-extended results to writeback.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/stage_mem_lsu_assemble.sv | 27 ++
 rtl/stage_mem_lsu.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
//   mem_op_e    : lsu op codes carried on mem_op_i
//   lsu_state_e : LSU sequencer states
//   is_load / is_store / nbytes / is_signed / is_legal : op decode helpers
package lsu_pkg;

  typedef enum logic [3:0] {
    NONE, LB, LH, LW, LBU, LHU, LWU, LD, SB, SH, SW, SD
  } mem_op_e;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, FIN} lsu_state_e;

  function automatic logic is_load(mem_op_e op);
    return op inside {LB, LH, LW, LBU, LHU, LWU, LD};
  endfunction

  function automatic logic is_store(mem_op_e op);
    return op inside {SB, SH, SW, SD};
  endfunction

  function automatic logic [3:0] nbytes(mem_op_e op);
    case (op)
      LB, LBU, SB:  return 4'd1;
      LH, LHU, SH:  return 4'd2;
      LW, LWU, SW:  return 4'd4;
      LD, SD:       return 4'd8;
      default:      return 4'd0;
    endcase
  endfunction

  function automatic logic is_signed(mem_op_e op);
    return op inside {LB, LH, LW, LD};
  endfunction

  // 32-bit cores have no doubleword or unsigned-word access
  function automatic logic is_legal(mem_op_e op, int xlen);
    return !(xlen == 32 && op inside {LWU, LD, SD});
  endfunction

endpackage

// File: rtl/stage_mem_lsu_assemble.sv
// lsu_load_assemble: combinational load result builder.
//   lanes : captured bytes, lane k = byte at base+k (little-endian)
//   nb    : bytes in the access (1/2/4/8)
//   sgn   : sign-extend from the top loaded byte, else zero-extend
//   res   : XLEN-wide writeback value
module lsu_load_assemble #(
  parameter int XLEN = 32
) (
  input  logic [7:0][7:0]  lanes,
  input  logic [3:0]       nb,
  input  logic             sgn,
  output logic [XLEN-1:0]  res
);

  logic [2:0] top;
  logic       msb;

  assign top = 3'(nb - 4'd1);
  assign msb = sgn & lanes[top][7];

  always_comb begin
    res = '0;
    for (int i = 0; i < XLEN/8; i++)
      res[8*i +: 8] = (4'(i) < nb) ? lanes[i] : {8{msb}};
  end

endmodule

// File: rtl/stage_mem_lsu.sv
// stage_mem_lsu: MEM pipeline stage with a byte-serial load/store unit.
//   clk, rst (sync, active-high)
//   valid_i, mem_op_i, addr_i, sdata_i, wd_i, wreg_i, wdata_i : from EX/MEM
//   wd_o, wreg_o, wdata_o : registered writeback to WB
//   stall_req_o           : freeze upstream while an access is in flight
//   mem_a_o, mem_wr_o, mem_dout_o, mem_din_i : byte-wide memory port
// Optional: define STAGE_MEM_LSU_PAUSE_EN to add rdy_i; rdy_i=0 holds all
// state, suppresses writes and forces a stall.
module stage_mem_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef STAGE_MEM_LSU_PAUSE_EN
  input  logic              rdy_i,
`endif
  input  logic              valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   sdata_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i
);

  localparam int CW = 4;  // cycle index reaches 8-1+4 = 11

  logic en;
`ifdef STAGE_MEM_LSU_PAUSE_EN
  assign en = rdy_i;
`else
  assign en = 1'b1;
`endif

  lsu_state_e        st_q, st_d;
  mem_op_e           op_q, op_in;
  logic [ADDR_W-1:0] base_q, a_base;
  logic [XLEN-1:0]   sdata_q, sd;
  logic [7:0][7:0]   sd_b;
  logic [4:0]        wd_q;
  logic              wreg_q;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [7:0][7:0]   lane_q, lane_d;
  logic [XLEN-1:0]   ld_res;
  logic              acc_mem, multi, wr_act;

  // Cycle index (accept = 0) of the final cycle of an access
  function automatic logic [CW-1:0] last_cyc(mem_op_e op);
    if (is_load(op)) return CW'(nbytes(op)) + CW'(RD_LAT) - CW'(1);
    return CW'(nbytes(op)) - CW'(1);
  endfunction

  function automatic lsu_state_e classify(logic [CW-1:0] c, mem_op_e op);
    if (c == last_cyc(op))    return FIN;
    if (c < CW'(nbytes(op)))  return XFER;
    return DRAIN;
  endfunction

  assign op_in   = mem_op_e'(mem_op_i);
  assign acc_mem = valid_i && is_legal(op_in, XLEN) && (is_load(op_in) || is_store(op_in));
  assign multi   = acc_mem && (last_cyc(op_in) != '0);

  always_comb begin
    st_d  = st_q;
    cyc_d = cyc_q;
    case (st_q)
      IDLE: if (multi) begin
        cyc_d = CW'(1);
        st_d  = classify(CW'(1), op_in);
      end
      XFER, DRAIN: begin
        cyc_d = cyc_q + CW'(1);
        st_d  = classify(cyc_q + CW'(1), op_q);
      end
      FIN: begin
        cyc_d = '0;
        st_d  = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // Byte 0 comes straight from the EX/MEM inputs in the accept cycle
  assign a_base     = (st_q == IDLE) ? addr_i  : base_q;
  assign sd         = (st_q == IDLE) ? sdata_i : sdata_q;
  assign sd_b       = 64'(sd);
  assign mem_a_o    = a_base + ADDR_W'(cyc_q);
  assign mem_dout_o = sd_b[cyc_q[2:0]];

  assign wr_act = (st_q == IDLE && acc_mem && is_store(op_in)) ||
                  ((st_q == XFER || st_q == FIN) && is_store(op_q));
  assign mem_wr_o    = wr_act && en && !rst;
  assign stall_req_o = (st_q == IDLE && multi) || st_q == XFER || st_q == DRAIN || !en;

  // Byte presented in cycle k lands RD_LAT cycles later into lane k
  always_comb begin
    lane_d = lane_q;
    if (st_q != IDLE && is_load(op_q) && cyc_q >= CW'(RD_LAT))
      lane_d[3'(cyc_q - CW'(RD_LAT))] = mem_din_i;
  end

  // The final byte is merged in the FIN cycle itself via lane_d
  lsu_load_assemble #(.XLEN(XLEN)) u_asm (
    .lanes (lane_d),
    .nb    (nbytes(op_q)),
    .sgn   (is_signed(op_q)),
    .res   (ld_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      cyc_q   <= '0;
      wd_o    <= '0;
      wreg_o  <= 1'b0;
      wdata_o <= '0;
    end else if (en) begin
      st_q   <= st_d;
      cyc_q  <= cyc_d;
      lane_q <= lane_d;
      wreg_o <= 1'b0;
      if (st_q == IDLE && acc_mem) begin
        op_q    <= op_in;
        base_q  <= addr_i;
        sdata_q <= sdata_i;
        wd_q    <= wd_i;
        wreg_q  <= wreg_i;
      end
      if (st_q == IDLE && valid_i && !acc_mem) begin
        // unknown or illegal op codes never write a register
        wd_o    <= wd_i;
        wreg_o  <= wreg_i && (op_in == NONE);
        wdata_o <= wdata_i;
      end else if (st_q == IDLE && acc_mem && !multi) begin
        wd_o <= '0;
      end else if (st_q == FIN) begin
        if (is_load(op_q)) begin
          wd_o    <= wd_q;
          wreg_o  <= wreg_q;
          wdata_o <= ld_res;
        end else begin
          wd_o    <= '0;
          wdata_o <= '0;
        end
      end
    end
  end

endmodule
